// File: rtl/control_bus_rtc_pkg.sv
// Shared definitions for the RTC bus sequencer: state encoding, ack bit
// positions, default status address and the fixed-priority arbiter.
package control_bus_rtc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIR    = 3'd1,
        ESPERA = 3'd2,
        DATO   = 3'd3,
        FIN    = 3'd4
    } estado_t;

    localparam int ACK_STATUS = 0;
    localparam int ACK_ESCR   = 1;
    localparam int ACK_LECT   = 2;

    localparam logic [7:0] DIR_STATUS_DEF = 8'h00;

    // Status writes win over general writes, which win over reads.
    function automatic logic [2:0] arbitrar(input logic rs, input logic re, input logic rl);
        logic [2:0] g;
        g = 3'b000;
        if (rs) begin
            g[ACK_STATUS] = 1'b1;
        end else if (re) begin
            g[ACK_ESCR] = 1'b1;
        end else if (rl) begin
            g[ACK_LECT] = 1'b1;
        end else begin
            g = 3'b000;
        end
        return g;
    endfunction

endpackage

// File: rtl/control_bus_rtc_contador_fase.sv
// Phase-length counter: counts cycles within a bus phase and flags the
// last cycle of the phase.
module contador_fase #(
    parameter int T_FASE = 4
) (
    input  logic reloj,
    input  logic resetM,
    input  logic clr,
    output logic tc
);

    localparam int CW = $clog2(T_FASE) + 1;

    logic [CW-1:0] cuenta_r;

    // Cycle counter, restarted at every state change.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            cuenta_r <= '0;
        end else if (clr) begin
            cuenta_r <= '0;
        end else begin
            cuenta_r <= cuenta_r + CW'(1);
        end
    end

    assign tc = (cuenta_r == CW'(T_FASE - 1));

endmodule

// File: rtl/control_bus_rtc.sv
// Arbiter and fixed-phase sequencer for the multiplexed address/data bus
// of the external RTC chip.
module control_bus_rtc
    import control_bus_rtc_pkg::*;
#(
    parameter int         T_FASE     = 4,
    parameter logic [7:0] DIR_STATUS = DIR_STATUS_DEF
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       req_status,
    input  logic [7:0] dato_status,
    input  logic       req_escr,
    input  logic [7:0] dir_escr,
    input  logic [7:0] dato_escr,
    input  logic       req_lect,
    input  logic [7:0] dir_lect,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       rd_n,
    output logic [2:0] ack,
    output logic [7:0] dato_leido,
    output logic       lect_valida,
    output logic       ocupado
);

    estado_t    estado_r, estado_sig_s;
    logic [2:0] gnt_r, gnt_sig_s, gnt_nuevo_s;
    logic [7:0] dir_r, dir_sig_s;
    logic [7:0] dato_r, dato_sig_s;
    logic       tc_s, clr_s;

    logic [7:0] ad_out_s;
    logic       ad_oe_s, cs_n_s, a_d_s, wr_n_s, rd_n_s, lect_valida_s;
    logic [2:0] ack_s;

    // Counter is held at zero in IDLE so every phase starts from a clean count.
    assign clr_s = (estado_sig_s != estado_r) || (estado_r == IDLE);

    contador_fase #(.T_FASE(T_FASE)) u_contador_fase (
        .reloj  (reloj),
        .resetM (resetM),
        .clr    (clr_s),
        .tc     (tc_s)
    );

    // Next-state sequencing through the fixed bus phases.
    always_comb begin
        estado_sig_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (req_status || req_escr || req_lect) begin
                    estado_sig_s = DIR;
                end else begin
                    estado_sig_s = IDLE;
                end
            end
            DIR: begin
                if (tc_s) estado_sig_s = ESPERA;
                else      estado_sig_s = DIR;
            end
            ESPERA: begin
                if (tc_s) estado_sig_s = DATO;
                else      estado_sig_s = ESPERA;
            end
            DATO: begin
                if (tc_s) estado_sig_s = FIN;
                else      estado_sig_s = DATO;
            end
            FIN:     estado_sig_s = IDLE;
            default: estado_sig_s = IDLE;
        endcase
    end

    // Grant, address and write data are captured only while idle.
    always_comb begin
        gnt_nuevo_s = arbitrar(req_status, req_escr, req_lect);
        gnt_sig_s   = gnt_r;
        dir_sig_s   = dir_r;
        dato_sig_s  = dato_r;
        if (estado_r == IDLE) begin
            gnt_sig_s = gnt_nuevo_s;
            if (gnt_nuevo_s[ACK_STATUS]) begin
                dir_sig_s  = DIR_STATUS;
                dato_sig_s = dato_status;
            end else if (gnt_nuevo_s[ACK_ESCR]) begin
                dir_sig_s  = dir_escr;
                dato_sig_s = dato_escr;
            end else if (gnt_nuevo_s[ACK_LECT]) begin
                dir_sig_s  = dir_lect;
                dato_sig_s = 8'h00;
            end else begin
                dir_sig_s  = dir_r;
                dato_sig_s = dato_r;
            end
        end else begin
            gnt_sig_s = gnt_r;
        end
    end

    // Pad/strobe values for the state being entered, so the registered
    // outputs line up with the state itself.
    always_comb begin
        ad_out_s      = 8'h00;
        ad_oe_s       = 1'b0;
        cs_n_s        = 1'b1;
        a_d_s         = 1'b0;
        wr_n_s        = 1'b1;
        rd_n_s        = 1'b1;
        ack_s         = 3'b000;
        lect_valida_s = 1'b0;
        case (estado_sig_s)
            IDLE:   ack_s = 3'b000;
            DIR: begin
                cs_n_s   = 1'b0;
                wr_n_s   = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = dir_sig_s;
            end
            ESPERA: cs_n_s = 1'b1;
            DATO: begin
                cs_n_s = 1'b0;
                a_d_s  = 1'b1;
                if (gnt_sig_s[ACK_LECT]) begin
                    rd_n_s = 1'b0;
                end else begin
                    wr_n_s   = 1'b0;
                    ad_oe_s  = 1'b1;
                    ad_out_s = dato_sig_s;
                end
            end
            FIN: begin
                ack_s         = gnt_r;
                lect_valida_s = gnt_r[ACK_LECT];
            end
            default: ack_s = 3'b000;
        endcase
    end

    // State, latched transaction and registered bus outputs.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            estado_r    <= IDLE;
            gnt_r       <= 3'b000;
            dir_r       <= 8'h00;
            dato_r      <= 8'h00;
            ad_out      <= 8'h00;
            ad_oe       <= 1'b0;
            cs_n        <= 1'b1;
            a_d         <= 1'b0;
            wr_n        <= 1'b1;
            rd_n        <= 1'b1;
            ack         <= 3'b000;
            dato_leido  <= 8'h00;
            lect_valida <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            estado_r    <= estado_sig_s;
            gnt_r       <= gnt_sig_s;
            dir_r       <= dir_sig_s;
            dato_r      <= dato_sig_s;
            ad_out      <= ad_out_s;
            ad_oe       <= ad_oe_s;
            cs_n        <= cs_n_s;
            a_d         <= a_d_s;
            wr_n        <= wr_n_s;
            rd_n        <= rd_n_s;
            ack         <= ack_s;
            lect_valida <= lect_valida_s;
            ocupado     <= (estado_sig_s != IDLE);
            if ((estado_r == DATO) && tc_s && gnt_r[ACK_LECT]) begin
                dato_leido <= ad_in;
            end else begin
                dato_leido <= dato_leido;
            end
        end
    end

endmodule
